// File: rtl/ref_window_fetch.sv
// ref_window_fetch: turns one affine sub-block MV into per-row reference fetch requests.
// Latency: MV accepted at edge t -> row 0 request valid for the edge at t+2; H+2 cycles per block.
// Backpressure: MV_READY only in IDLE; REQ_* / OUT_* hold while REQ_VALID && !REQ_READY.
//
// Ports:
//   CLK, RST                  rising-edge clock, synchronous active-high reset
//   CU_X/CU_Y, BLOCK_X/Y      CU origin and sub-block offset, latched on MV accept
//   MV_{X,Y}_INT/_FRAC        integer + 1/16 fractional MV per axis
//   MV_VALID/MV_READY         input bundle handshake
//   REQ_VALID/REQ_READY       row request handshake
//   REQ_X/REQ_Y/REQ_LEN/LAST  row start x (unclamped), clamped row y, row length, last-row flag
//   OUT_FRAC_*/OUT_INTERP_*   fractions and interpolation flags of the current window
//   BUSY                      any state other than IDLE
module ref_window_fetch #(
    parameter int PIC_W = 1920,
    parameter int PIC_H = 1080,
    parameter int BLK   = 4,
    parameter int TAPS  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] CU_X,
    input  logic [11:0] CU_Y,
    input  logic [7:0]  BLOCK_X,
    input  logic [7:0]  BLOCK_Y,
    input  logic [14:0] MV_X_INT,
    input  logic [14:0] MV_Y_INT,
    input  logic [3:0]  MV_X_FRAC,
    input  logic [3:0]  MV_Y_FRAC,
    input  logic        MV_VALID,
    output logic        MV_READY,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic [12:0] REQ_X,
    output logic [10:0] REQ_Y,
    output logic [3:0]  REQ_LEN,
    output logic        REQ_LAST,
    output logic [3:0]  OUT_FRAC_X,
    output logic [3:0]  OUT_FRAC_Y,
    output logic        OUT_INTERP_X,
    output logic        OUT_INTERP_Y,
    output logic        BUSY
);

    // Window margins around the block for the interpolation filter.
    localparam int MARG_PRE  = TAPS / 2 - 1;
    localparam int MARG_POST = TAPS / 2;
    localparam int WIN       = BLK + MARG_PRE + MARG_POST;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched input bundle
    logic [11:0] r_cu_x;
    logic [11:0] r_cu_y;
    logic [7:0]  r_blk_x;
    logic [7:0]  r_blk_y;
    logic [14:0] r_mv_x;
    logic [14:0] r_mv_y;
    logic [3:0]  r_frac_x;
    logic [3:0]  r_frac_y;
    logic        r_interp_x;
    logic        r_interp_y;

    // Window geometry computed in CALC
    logic signed [16:0] r_base_x;
    logic signed [16:0] r_base_y;
    logic [3:0]         r_len;
    logic [3:0]         r_h;
    logic [3:0]         r_row;

    // Handshake / control wires
    logic w_mv_ready;
    logic w_req_valid;
    logic w_busy;
    logic w_accept;
    logic w_fire;
    logic w_row_last;

    // Arithmetic wires
    logic signed [16:0] w_ix;
    logic signed [16:0] w_iy;
    logic signed [16:0] w_base_x;
    logic signed [16:0] w_base_y;
    logic signed [16:0] w_y_sum;
    logic [10:0]        w_req_y;

    // Only the low 13 bits of base_x leave the block (line buffer wraps/pads x);
    // the picture width matters only to that line buffer, not here.
    logic w_unused_hi_x;
    logic w_unused_pic_w;
    assign w_unused_hi_x  = ^r_base_x[16:13];
    assign w_unused_pic_w = (PIC_W > 0);

    //------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_row_last = (r_row == 4'(r_h - 4'd1));

    //------------------------------------------------------------------
    // FSM next state and handshake outputs. Outputs are also masked by RST
    // so nothing handshakes during the reset cycle, whatever the state.
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mv_ready  = 1'b0;
        w_req_valid = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mv_ready = ~RST;
                w_accept   = MV_VALID & w_mv_ready;
                if (w_accept) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_busy      = ~RST;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_busy      = ~RST;
                w_req_valid = ~RST;
                w_fire      = w_req_valid & REQ_READY;
                if (w_fire && w_row_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Window arithmetic, 17-bit signed. CU coordinates are unsigned,
    // block offsets and MVs are sign-extended.
    //------------------------------------------------------------------
    assign w_ix = signed'({5'd0, r_cu_x})
                + signed'({{9{r_blk_x[7]}}, r_blk_x})
                + signed'({{2{r_mv_x[14]}}, r_mv_x});
    assign w_iy = signed'({5'd0, r_cu_y})
                + signed'({{9{r_blk_y[7]}}, r_blk_y})
                + signed'({{2{r_mv_y[14]}}, r_mv_y});

    assign w_base_x = w_ix - (r_interp_x ? 17'(MARG_PRE) : 17'd0);
    assign w_base_y = w_iy - (r_interp_y ? 17'(MARG_PRE) : 17'd0);

    // Rows above/below the picture repeat the edge row.
    assign w_y_sum = r_base_y + signed'({13'd0, r_row});

    always_comb begin
        w_req_y = w_y_sum[10:0];
        if (w_y_sum < 17'sd0) begin
            w_req_y = 11'd0;
        end else if (w_y_sum > signed'(17'(PIC_H - 1))) begin
            w_req_y = 11'(PIC_H - 1);
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cu_x     <= '0;
            r_cu_y     <= '0;
            r_blk_x    <= '0;
            r_blk_y    <= '0;
            r_mv_x     <= '0;
            r_mv_y     <= '0;
            r_frac_x   <= '0;
            r_frac_y   <= '0;
            r_interp_x <= 1'b0;
            r_interp_y <= 1'b0;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_len      <= '0;
            r_h        <= '0;
            r_row      <= '0;
        end else begin
            if (w_accept) begin
                r_cu_x     <= CU_X;
                r_cu_y     <= CU_Y;
                r_blk_x    <= BLOCK_X;
                r_blk_y    <= BLOCK_Y;
                r_mv_x     <= MV_X_INT;
                r_mv_y     <= MV_Y_INT;
                r_frac_x   <= MV_X_FRAC;
                r_frac_y   <= MV_Y_FRAC;
                r_interp_x <= (MV_X_FRAC != 4'd0);
                r_interp_y <= (MV_Y_FRAC != 4'd0);
            end
            if (r_state == S_CALC) begin
                r_base_x <= w_base_x;
                r_base_y <= w_base_y;
                r_len    <= r_interp_x ? 4'(WIN) : 4'(BLK);
                r_h      <= r_interp_y ? 4'(WIN) : 4'(BLK);
                r_row    <= 4'd0;
            end
            // Counter parks at 0 after the last row instead of running past H-1.
            if (w_fire) begin
                r_row <= w_row_last ? 4'd0 : 4'(r_row + 4'd1);
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign MV_READY     = w_mv_ready;
    assign REQ_VALID    = w_req_valid;
    assign BUSY         = w_busy;
    assign REQ_LAST     = w_req_valid & w_row_last;
    assign REQ_X        = r_base_x[12:0];
    assign REQ_Y        = w_req_y;
    assign REQ_LEN      = r_len;
    assign OUT_FRAC_X   = r_frac_x;
    assign OUT_FRAC_Y   = r_frac_y;
    assign OUT_INTERP_X = r_interp_x;
    assign OUT_INTERP_Y = r_interp_y;

endmodule
